// File: rtl/uart_pkg.sv
// Shared encodings for the UART transmit-side blocks.
package uart_pkg;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;
endpackage

// File: rtl/uart_tx_arb_rr_pick.sv
// Combinational round-robin search: first set req bit after 'last', wrapping modulo NREQ.
module rr_pick #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [2:0]      last,
  output logic [2:0]      win,
  output logic            any
);
  logic [NREQ-1:0] rot;

  // Rotate so bit 0 is the requester right after 'last'; last+1 wraps to 0 only when NREQ=8.
  assign rot = NREQ'({req, req} >> (last + 3'd1));

  always_comb begin
    win = '0;
    any = 1'b0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (rot[j]) begin
        win = 3'((int'(last) + 1 + j) % NREQ);
        any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one UART transmitter among NREQ byte producers.
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int NREQ     = 2,
  parameter int START_TO = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [DATA_W*NREQ-1:0] req_data,
  output logic [NREQ-1:0]        req_ready,
  output logic                   tx_start,
  output logic [DATA_W-1:0]      tx_data,
  input  logic                   tx_busy,
  output logic [2:0]             grant_id,
  output logic                   start_err
);
  localparam int CW = (START_TO > 2) ? $clog2(START_TO) : 1;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic [2:0]    win;
  logic          any;
  logic          pick_ok;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req  (req_valid),
    .last (grant_id),
    .win  (win),
    .any  (any)
  );

  // Accept is combinational on req_valid so a late requester still competes this cycle.
  assign pick_ok   = (state == IDLE) && !tx_busy && any;
  assign req_ready = (reset && pick_ok) ? (NREQ'(1) << win) : '0;
  assign cnt_nxt   = cnt + CW'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      tx_start  <= 1'b0;
      tx_data   <= '0;
      grant_id  <= 3'(NREQ - 1);
      start_err <= 1'b0;
      cnt       <= '0;
    end else begin
      tx_start <= 1'b0;
      case (state)
        IDLE: if (pick_ok) begin
          tx_data  <= DATA_W'(req_data >> (DATA_W * int'(win)));
          grant_id <= win;
          tx_start <= 1'b1;
          state    <= LAUNCH;
        end
        LAUNCH: begin
          cnt   <= '0;
          state <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (tx_busy) begin
            cnt   <= '0;
            state <= WAIT_DONE;
          end else if (cnt_nxt == CW'(START_TO - 1)) begin
            // Transmitter never picked the byte up: flag it and drop the byte.
            start_err <= 1'b1;
            cnt       <= '0;
            state     <= IDLE;
          end else begin
            cnt <= cnt_nxt;
          end
        end
        WAIT_DONE: if (!tx_busy) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: timestamp-based reference model plus directed timing checks.
module tb_uart_tx_arb;
  localparam int NREQ     = 2;
  localparam int START_TO = 16;
  localparam int INF      = 1 << 30;

  logic             clk = 1'b0;
  logic             reset;
  logic [NREQ-1:0]  req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]  req_ready;
  logic             tx_start;
  logic [7:0]       tx_data;
  logic             tx_busy;
  logic [2:0]       grant_id;
  logic             start_err;

  int total = 0;
  int bad   = 0;

  // tx model controls
  int busy_len = 10;
  bit tx_dead  = 0;

  uart_tx_arb #(.NREQ(NREQ), .START_TO(START_TO)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .tx_busy   (tx_busy),
    .grant_id  (grant_id),
    .start_err (start_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Returns at the negedge of the first cycle with any req_ready bit set.
  task automatic wait_ready(output int n);
    n = 0;
    forever begin
      @(negedge clk);
      if (req_ready != '0) return;
      n++;
      if (n >= 60) begin
        total++;
        bad++;
        $display("FAIL wait_ready timeout after %0d cycles", n);
        return;
      end
    end
  endtask

  function automatic int rr_exp(input int last, input logic [NREQ-1:0] v);
    for (int k = 1; k <= NREQ; k++) begin
      int i;
      i = (last + k) % NREQ;
      if (((v >> i) & 1) != 0) return i;
    end
    return -1;
  endfunction

  // Transmitter model: busy rises the cycle after a start strobe, lasts busy_len cycles.
  initial begin
    int left;
    bit pend;
    left = 0;
    pend = 0;
    tx_busy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!reset) begin
        tx_busy = 1'b0;
        left = 0;
        pend = 0;
      end else begin
        if (left > 0) begin
          left--;
          if (left == 0) tx_busy = 1'b0;
        end else if (pend) begin
          tx_busy = 1'b1;
          left = busy_len;
          pend = 0;
        end
        if (tx_start && !tx_dead) pend = 1;
      end
    end
  end

  // Reference model: arbiter availability tracked as cycle timestamps.
  initial begin
    int cyc, m_last, m_start, m_ready_at, m_deadline, w;
    bit m_err, m_rose;
    logic [7:0] m_data;
    logic [NREQ-1:0] exp_rdy;
    cyc = 0;
    m_last = NREQ - 1; m_err = 0; m_data = 0; m_start = -1;
    m_ready_at = 0; m_rose = 0; m_deadline = INF;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset) begin
        m_last = NREQ - 1; m_err = 0; m_data = 0; m_start = -1;
        m_ready_at = 0; m_rose = 0; m_deadline = INF;
        chk("rst_ready", req_ready, 0);
        chk("rst_start", tx_start, 0);
        chk("rst_data", tx_data, 0);
        chk("rst_gid", grant_id, NREQ - 1);
        chk("rst_err", start_err, 0);
      end else begin
        w = (cyc >= m_ready_at && !tx_busy) ? rr_exp(m_last, req_valid) : -1;
        exp_rdy = (w >= 0) ? NREQ'(1 << w) : '0;
        chk("m_ready", req_ready, exp_rdy);
        chk("m_start", tx_start, (cyc == m_start));
        chk("m_data", tx_data, m_data);
        chk("m_gid", grant_id, m_last);
        chk("m_err", start_err, m_err);
        chk("m_onehot", ($countones(req_ready) <= 1), 1);
        if (w >= 0) begin
          m_data = 8'((req_data >> (8 * w)) & 'hFF);
          m_last = w;
          m_start = cyc + 1;
          m_ready_at = INF;
          m_rose = 0;
          m_deadline = cyc + 1 + START_TO;
        end else if (m_ready_at == INF && cyc > m_start) begin
          if (!m_rose) begin
            if (tx_busy) m_rose = 1;
            else if (cyc + 1 == m_deadline) begin
              m_err = 1;
              m_ready_at = cyc + 1;
            end
          end else if (!tx_busy) begin
            m_ready_at = cyc + 1;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Directed stimulus with hand-computed timing.
  initial begin
    int n, m;
    reset = 1'b0; req_valid = '0; req_data = '0;
    repeat (3) tick();

    // Single requester, zero accept latency, gap of busy_len+3 cycles between grants.
    reset = 1'b1; req_valid = 2'b01; req_data = 16'h00A5;
    wait_ready(n);
    chk("t1_lat", n, 0);
    chk("t1_ready", req_ready, 2'b01);
    @(negedge clk);
    chk("t1_start", tx_start, 1);
    chk("t1_data", tx_data, 8'hA5);
    chk("t1_gid", grant_id, 0);
    tick();
    req_data = 16'h005A;
    wait_ready(n);
    chk("t1_gap", n, 11);
    tick();
    req_valid = '0;

    // Both valid after a fresh reset: 0,1,0,1.
    tick(); reset = 1'b0; tick(); tick();
    reset = 1'b1; req_valid = 2'b11; req_data = 16'h2211;
    for (int k = 0; k < 4; k++) begin
      wait_ready(n);
      chk("t2_order", req_ready, (k % 2) ? 2'b10 : 2'b01);
      @(negedge clk);
      chk("t2_data", tx_data, (k % 2) ? 8'h22 : 8'h11);
    end
    tick();
    req_valid = '0;

    // Transmitter never goes busy: start_err START_TO cycles after the strobe.
    repeat (14) tick();
    tx_dead = 1; req_valid = 2'b01; req_data = 16'h0077;
    wait_ready(n);
    @(negedge clk);
    chk("t3_start", tx_start, 1);
    tick();
    req_valid = 2'b10; req_data = 16'h9900; tx_dead = 0;
    m = 0;
    forever begin
      @(negedge clk);
      m++;
      if (start_err || m >= 40) break;
    end
    chk("t3_err_lat", m, START_TO);
    chk("t3_regrant", req_ready, 2'b10);
    @(negedge clk);
    chk("t3_data", tx_data, 8'h99);
    chk("t3_gid", grant_id, 1);
    tick();
    req_valid = '0;

    // Requester 1 raises valid in the cycle busy falls.
    n = 0;
    while (!tx_busy && n < 20) begin tick(); n++; end
    n = 0;
    while (tx_busy && n < 20) begin tick(); n++; end
    req_valid = 2'b10; req_data = 16'h3C00;
    wait_ready(n);
    chk("t4_lat", n, 1);
    chk("t4_ready", req_ready, 2'b10);
    @(negedge clk);
    chk("t4_data", tx_data, 8'h3C);

    // Async reset during WAIT_DONE.
    tick();
    req_valid = 2'b01; req_data = 16'h0042;
    wait_ready(n);
    chk("t5_ready", req_ready, 2'b01);
    tick();
    req_valid = '0;
    repeat (4) tick();
    chk("t5_pre_gid", grant_id, 0);
    chk("t5_pre_err", start_err, 1);
    chk("t5_pre_busy", tx_busy, 1);
    req_valid = 2'b11; req_data = 16'h2211;
    #1 reset = 1'b0;
    #1;
    chk("t5_start", tx_start, 0);
    chk("t5_ready0", req_ready, 0);
    chk("t5_gid", grant_id, NREQ - 1);
    chk("t5_err", start_err, 0);
    chk("t5_data", tx_data, 0);
    tick(); tick();
    reset = 1'b1;
    wait_ready(n);
    chk("t5_relat", n, 0);
    chk("t5_win0", req_ready, 2'b01);
    @(negedge clk);
    chk("t5_txd", tx_data, 8'h11);
    tick();
    req_valid = '0;
    repeat (15) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
